// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply/divide unit, one bit per clock.
// Optional build macro MULTDIV_EARLY_ZERO_EN: zero operands finish one edge after start.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      count;
    // Multiply: {partial high, multiplier}; divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               neg;
    logic               zero_op;
    logic               skip;

    logic               start;
    logic               start_zero;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign a_neg      = data_operandA[WIDTH-1];
    assign b_neg      = data_operandB[WIDTH-1];
    assign a_mag      = a_neg ? (~data_operandA + 1'b1) : data_operandA;
    assign b_mag      = b_neg ? (~data_operandB + 1'b1) : data_operandB;
    assign start_zero = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                  : (data_operandB == '0);
    assign last       = (count == CW'(WIDTH - 1));

    // Shift-add step: add multiplicand into the high half when the multiplier LSB is set.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide step; the bit shifted out of the remainder acts as a carry.
    logic               div_carry;
    logic [WIDTH-1:0]   div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign div_carry = acc[2*WIDTH-1];
    assign div_shift = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_carry | (div_shift >= opb);
    assign div_rem   = div_ge ? (div_shift - opb) : div_shift;
    assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    assign prod = neg ? (~mul_next + 1'b1) : mul_next;
    assign quo  = neg ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];

    always_comb begin
        fin_result = '0;
        fin_exc    = 1'b0;
        if (zero_op) begin
            fin_result = '0;
            fin_exc    = (state_q == DIV);
        end else if (state_q == MUL) begin
            fin_result = prod[WIDTH-1:0];
            fin_exc    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        end else begin
            // Only a positive quotient of 2^(WIDTH-1) can overflow (MIN / -1).
            fin_result = quo;
            fin_exc    = !neg && div_next[WIDTH-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state_q)
                MUL, DIV: if (last) state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count          <= '0;
            acc            <= '0;
            opb            <= '0;
            neg            <= 1'b0;
            zero_op        <= 1'b0;
            skip           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            neg     <= a_neg ^ b_neg;
            zero_op <= start_zero;
            if (ctrl_MULT) begin
                acc <= {{WIDTH{1'b0}}, b_mag};
                opb <= a_mag;
            end else begin
                acc <= {{WIDTH{1'b0}}, a_mag};
                opb <= b_mag;
            end
`ifdef MULTDIV_EARLY_ZERO_EN
            skip  <= start_zero;
            count <= start_zero ? CW'(WIDTH - 1) : '0;
`else
            skip  <= 1'b0;
            count <= '0;
`endif
        end else if ((state_q == MUL) || (state_q == DIV)) begin
            acc   <= (state_q == MUL) ? mul_next : div_next;
            count <= count + 1'b1;
            if (last) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
            end
        end
    end

    assign data_resultRDY = (state_q == DONE);
    assign busy           = ((state_q == MUL) || (state_q == DIV)) && !skip;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard testbench for multdiv_unit with directed vectors.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

`ifdef MULTDIV_EARLY_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 32;
`endif

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(data_result), 64'(e.res));
                check({e.name, "_exc"}, 64'(data_exception), 64'(e.exc));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, input bit expect_rdy, input int lat,
                            input logic [31:0] res, input logic exc, input string name);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = m;
        ctrl_DIV = d;
        if (expect_rdy) begin
            e.res = res;
            e.exc = exc;
            e.cyc = cyc + 1 + lat;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        idle(2);
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        idle(2);

        start_op(1, 0, 32'd7, 32'hFFFFFFFD, 1, 32, 32'hFFFFFFEB, 1'b0, "mul_7x-3");
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            @(negedge clock);
        end
        check("mul_busy_cycles", 64'(bcnt), 64'd32);

        start_op(1, 0, 32'h00010000, 32'h00010000, 1, 32, 32'h0, 1'b1, "mul_ovf_2^32");
        check("result_hold_on_start", 64'(data_result), 64'hFFFFFFEB);
        idle(36);
        start_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 1, 32, 32'h80000000, 1'b1, "mul_min_x-1");
        idle(36);
        start_op(1, 0, 32'd0, 32'd123, 1, ZLAT, 32'h0, 1'b0, "mul_zero");
        idle(36);
        start_op(0, 1, 32'hFFFFFFF9, 32'd2, 1, 32, 32'hFFFFFFFD, 1'b0, "div_-7/2");
        idle(36);
        start_op(0, 1, 32'd100, 32'hFFFFFFF9, 1, 32, 32'hFFFFFFF2, 1'b0, "div_100/-7");
        idle(36);
        start_op(0, 1, 32'd5, 32'd0, 1, ZLAT, 32'h0, 1'b1, "div_by_zero");
        idle(36);
        start_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32, 32'h80000000, 1'b1, "div_min/-1");
        idle(36);

        start_op(0, 1, 32'd9, 32'd3, 0, 0, 32'h0, 1'b0, "div_aborted");
        idle(8);
        start_op(1, 0, 32'd6, 32'd7, 1, 32, 32'd42, 1'b0, "restart_mul");
        idle(36);
        start_op(1, 1, 32'd5, 32'd3, 1, 32, 32'd15, 1'b0, "both_strobes");
        idle(36);

        start_op(1, 0, 32'd6, 32'd7, 0, 0, 32'h0, 1'b0, "mul_reset");
        idle(13);
        reset = 1'b0;
        #1;
        check("async_reset_result", 64'(data_result), 64'd0);
        check("async_reset_exc", 64'(data_exception), 64'd0);
        check("async_reset_rdy", 64'(data_resultRDY), 64'd0);
        check("async_reset_busy", 64'(busy), 64'd0);
        idle(3);
        reset = 1'b1;
        idle(40);
        start_op(1, 0, 32'd6, 32'd7, 1, 32, 32'd42, 1'b0, "mul_after_reset");
        idle(40);
        check("hold_result_idle", 64'(data_result), 64'd42);
        check("hold_exc_idle", 64'(data_exception), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
